psola_playback: RTL and testbench

//  Downstream of the PSOLA overlap-add stage. On a window-length strobe it reads the accumulated Q.FRAC_BITS

---
 rtl/psola_playback.sv | 204 ++++++++++++++++++++
 tb/tb_psola_playback.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/psola_playback.sv
// PSOLA output playback: prefetches the overlap-add buffer into a small FIFO and emits one saturated PCM
// sample per audio tick. Optional buffer clear-on-read is enabled by defining PSOLA_CLEAR_ON_READ_EN.
module psola_playback #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FRAC_BITS    = 10,
  parameter int unsigned OUT_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned BRAM_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [ADDR_WIDTH-1:0] window_len_in,
  input  logic                  window_len_valid_in,
  input  logic                  sample_tick_in,
  output logic [ADDR_WIDTH-1:0] read_addr_out,
  input  logic [DATA_WIDTH-1:0] read_data_in,
  output logic [OUT_WIDTH-1:0]  sample_out,
  output logic                  sample_valid_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  underrun_out
`ifdef PSOLA_CLEAR_ON_READ_EN
  ,
  output logic [ADDR_WIDTH-1:0] clear_addr_out,
  output logic                  clear_we_out
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX =
    $signed({{(DATA_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN =
    $signed({{(DATA_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]   pop_idx_q, pop_idx_d;
  logic                    rd_en_q, rd_en_d;
  logic [BRAM_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_q, wr_d, rdp_q, rdp_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   read_addr_q, read_addr_d;
  logic [OUT_WIDTH-1:0]    sample_q, sample_d;
  logic                    valid_q, valid_d, busy_q, busy_d;
  logic                    done_q, done_d, underrun_q, underrun_d;
  logic [ADDR_WIDTH-1:0]   clear_addr_q, clear_addr_d;
  logic                    clear_we_q, clear_we_d;

  logic [CNT_W-1:0]             infl;
  logic                         push, pop;
  logic signed [DATA_WIDTH-1:0] shifted;
  logic [OUT_WIDTH-1:0]         sat;

  // Next-state: read issue, tag pipe, FIFO, tick handling
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    rd_ptr_d     = rd_ptr_q;
    pop_idx_d    = pop_idx_q;
    rd_en_d      = 1'b0;
    fifo_mem_d   = fifo_mem_q;
    wr_d         = wr_q;
    rdp_d        = rdp_q;
    cnt_d        = cnt_q;
    read_addr_d  = read_addr_q;
    sample_d     = sample_q;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    underrun_d   = 1'b0;
    clear_addr_d = clear_addr_q;
    clear_we_d   = 1'b0;
    push         = vld_q[BRAM_LATENCY-1];
    pop          = 1'b0;

    infl = CNT_W'(rd_en_q);
    for (int i = 0; i < int'(BRAM_LATENCY); i++) infl = infl + CNT_W'(vld_q[i]);

    vld_d[0] = rd_en_q;
    for (int i = 1; i < int'(BRAM_LATENCY); i++) vld_d[i] = vld_q[i-1];

    shifted = $signed(fifo_mem_q[rdp_q]) >>> FRAC_BITS;
    if (shifted > SAT_MAX)      sat = OUT_WIDTH'(SAT_MAX);
    else if (shifted < SAT_MIN) sat = OUT_WIDTH'(SAT_MIN);
    else                        sat = OUT_WIDTH'(shifted);

    if (window_len_valid_in) begin
      // New window aborts everything in flight; a coincident tick emits silence
      len_d     = window_len_in;
      rd_ptr_d  = '0;
      pop_idx_d = '0;
      vld_d     = '0;
      wr_d      = '0;
      rdp_d     = '0;
      cnt_d     = '0;
      if (window_len_in != '0) begin
        state_d = S_PLAY;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      if (sample_tick_in) begin
        valid_d  = 1'b1;
        sample_d = '0;
      end
    end else begin
      if (state_q == S_PLAY && rd_ptr_q < len_q &&
          ({1'b0, cnt_q} + {1'b0, infl}) < DEPTH_V) begin
        rd_en_d     = 1'b1;
        read_addr_d = rd_ptr_q;
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
      end
      if (sample_tick_in) begin
        valid_d  = 1'b1;
        sample_d = '0;
        if (cnt_q != '0) begin
          pop          = 1'b1;
          sample_d     = sat;
          clear_we_d   = 1'b1;
          clear_addr_d = pop_idx_q;
          pop_idx_d    = pop_idx_q + ADDR_WIDTH'(1);
          if (pop_idx_q == len_q - ADDR_WIDTH'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (state_q == S_PLAY) begin
          underrun_d = 1'b1;
        end
      end
      if (push) begin
        fifo_mem_d[wr_q] = read_data_in;
        wr_d             = wr_q + PTR_W'(1);
      end
      if (pop) rdp_d = rdp_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
    busy_d = (state_d == S_PLAY);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      rd_ptr_q     <= '0;
      pop_idx_q    <= '0;
      rd_en_q      <= 1'b0;
      vld_q        <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem_q[i] <= '0;
      wr_q         <= '0;
      rdp_q        <= '0;
      cnt_q        <= '0;
      read_addr_q  <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      clear_addr_q <= '0;
      clear_we_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_ptr_q     <= rd_ptr_d;
      pop_idx_q    <= pop_idx_d;
      rd_en_q      <= rd_en_d;
      vld_q        <= vld_d;
      fifo_mem_q   <= fifo_mem_d;
      wr_q         <= wr_d;
      rdp_q        <= rdp_d;
      cnt_q        <= cnt_d;
      read_addr_q  <= read_addr_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
      clear_addr_q <= clear_addr_d;
      clear_we_q   <= clear_we_d;
    end
  end

  assign read_addr_out    = read_addr_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;
  assign underrun_out     = underrun_q;

`ifdef PSOLA_CLEAR_ON_READ_EN
  assign clear_addr_out = clear_addr_q;
  assign clear_we_out   = clear_we_q;
`else
  logic unused_clear;
  assign unused_clear = clear_we_q ^ (^clear_addr_q);
`endif

endmodule

// File: tb/tb_psola_playback.sv
// Directed bench for psola_playback with a BRAM model of latency 2 and a 16-entry buffer.
module tb_psola_playback;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [11:0] window_len_in = '0;
  logic        window_len_valid_in = 1'b0;
  logic        sample_tick_in = 1'b0;
  logic [11:0] read_addr_out;
  logic [31:0] read_data_in;
  logic [15:0] sample_out;
  logic        sample_valid_out, busy_out, done_out, underrun_out;
`ifdef PSOLA_CLEAR_ON_READ_EN
  logic [11:0] clear_addr_out;
  logic        clear_we_out;
`endif

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [31:0] mem [0:15];
  logic [11:0] addr_d0 = '0, addr_d1 = '0;

  always #5 clk_in = ~clk_in;

  // Buffer model: data for the address presented two cycles earlier
  always @(posedge clk_in) begin
    addr_d0 <= read_addr_out;
    addr_d1 <= addr_d0;
  end
  assign read_data_in = mem[addr_d1[3:0]];

  always @(negedge clk_in) if (done_out === 1'b1) done_cnt++;

  psola_playback dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .window_len_in(window_len_in), .window_len_valid_in(window_len_valid_in),
    .sample_tick_in(sample_tick_in),
    .read_addr_out(read_addr_out), .read_data_in(read_data_in),
    .sample_out(sample_out), .sample_valid_out(sample_valid_out),
    .busy_out(busy_out), .done_out(done_out), .underrun_out(underrun_out)
`ifdef PSOLA_CLEAR_ON_READ_EN
    , .clear_addr_out(clear_addr_out), .clear_we_out(clear_we_out)
`endif
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic strobe(input logic [11:0] len);
    @(negedge clk_in);
    window_len_in = len;
    window_len_valid_in = 1'b1;
    @(negedge clk_in);
    window_len_valid_in = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk_in);
    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
  endtask

  task automatic test_reset();
    idle(2);
    checks++; if (read_addr_out !== 12'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", read_addr_out); end
    checks++; if (sample_out !== 16'd0) begin failures++; $display("FAIL reset_sample got=%0d exp=0", sample_out); end
    checks++; if ({sample_valid_out, busy_out, done_out, underrun_out} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {sample_valid_out, busy_out, done_out, underrun_out}); end
    rst_in = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    logic [15:0] exp_s [3];
    exp_s[0] = 16'd1; exp_s[1] = 16'd2; exp_s[2] = 16'hFFFF;
    mem[0] = 32'd1024; mem[1] = 32'd2048; mem[2] = -32'sd1024;
    strobe(12'd3);
    checks++; if (busy_out !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy_out); end
    for (int i = 0; i < 3; i++) begin
      idle(7);
      tick();
      checks++; if (sample_out !== exp_s[i] || sample_valid_out !== 1'b1) begin
        failures++; $display("FAIL basic_sample%0d got=%0d/%b exp=%0d/1", i, $signed(sample_out), sample_valid_out, $signed(exp_s[i])); end
      checks++; if (done_out !== (i == 2) || underrun_out !== 1'b0) begin
        failures++; $display("FAIL basic_done%0d got=%b/%b exp=%b/0", i, done_out, underrun_out, (i == 2)); end
`ifdef PSOLA_CLEAR_ON_READ_EN
      checks++; if (clear_we_out !== 1'b1 || clear_addr_out !== 12'(i)) begin
        failures++; $display("FAIL clear%0d got=%b/%0d exp=1/%0d", i, clear_we_out, clear_addr_out, i); end
`endif
    end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", busy_out); end
    idle(1);
    checks++; if (sample_valid_out !== 1'b0 || done_out !== 1'b0) begin
      failures++; $display("FAIL basic_pulse got=%b/%b exp=0/0", sample_valid_out, done_out); end
  endtask

  task automatic test_saturation();
    mem[0] = 32'h7FFF_FFFF; mem[1] = 32'h8000_0000;
    strobe(12'd2);
    idle(8);
    tick();
    checks++; if (sample_out !== 16'h7FFF) begin failures++; $display("FAIL sat_pos got=%0d exp=32767", $signed(sample_out)); end
    idle(3);
    tick();
    checks++; if (sample_out !== 16'h8000 || done_out !== 1'b1) begin
      failures++; $display("FAIL sat_neg got=%0d/%b exp=-32768/1", $signed(sample_out), done_out); end
  endtask

  task automatic test_negative();
    mem[0] = 32'hFFFF_FFFF;
    strobe(12'd1);
    idle(8);
    tick();
    checks++; if (sample_out !== 16'hFFFF || done_out !== 1'b1) begin
      failures++; $display("FAIL neg_shift got=%0d/%b exp=-1/1", $signed(sample_out), done_out); end
  endtask

  task automatic test_len_zero();
    logic [11:0] a;
    a = read_addr_out;
    strobe(12'd0);
    checks++; if (done_out !== 1'b1 || busy_out !== 1'b0) begin
      failures++; $display("FAIL len0_done got=%b/%b exp=1/0", done_out, busy_out); end
    idle(3);
    checks++; if (done_out !== 1'b0 || read_addr_out !== a) begin
      failures++; $display("FAIL len0_addr got=%b/%0d exp=0/%0d", done_out, read_addr_out, a); end
    tick();
    checks++; if (sample_out !== 16'd0 || sample_valid_out !== 1'b1 || underrun_out !== 1'b0) begin
      failures++; $display("FAIL len0_tick got=%0d/%b/%b exp=0/1/0", sample_out, sample_valid_out, underrun_out); end
  endtask

  task automatic test_underrun();
    mem[0] = 32'd3072; mem[1] = 32'd4096; mem[2] = 32'd5120;
    @(negedge clk_in);
    window_len_in = 12'd3;
    window_len_valid_in = 1'b1;
    @(negedge clk_in);
    window_len_valid_in = 1'b0;
    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    checks++; if (underrun_out !== 1'b1 || sample_out !== 16'd0 || sample_valid_out !== 1'b1) begin
      failures++; $display("FAIL underrun got=%b/%0d/%b exp=1/0/1", underrun_out, sample_out, sample_valid_out); end
    for (int i = 0; i < 3; i++) begin
      idle(7);
      tick();
      checks++; if (sample_out !== 16'(i + 3) || underrun_out !== 1'b0 || done_out !== (i == 2)) begin
        failures++; $display("FAIL underrun_retry%0d got=%0d/%b/%b exp=%0d/0/%b", i, sample_out, underrun_out, done_out, i + 3, (i == 2)); end
    end
  endtask

  task automatic test_restart();
    for (int i = 0; i < 10; i++) mem[i] = 32'((i + 1) * 1024);
    strobe(12'd10);
    done_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      idle(7);
      tick();
      checks++; if (sample_out !== 16'(i + 1)) begin
        failures++; $display("FAIL restart_old%0d got=%0d exp=%0d", i, sample_out, i + 1); end
    end
    idle(3);
    strobe(12'd5);
    for (int i = 0; i < 5; i++) begin
      idle(7);
      tick();
      checks++; if (sample_out !== 16'(i + 1) || done_out !== (i == 4)) begin
        failures++; $display("FAIL restart_new%0d got=%0d/%b exp=%0d/%b", i, sample_out, done_out, i + 1, (i == 4)); end
    end
    idle(2);
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_async_reset();
    strobe(12'd10);
    idle(7);
    tick();
    checks++; if (sample_out !== 16'd1) begin failures++; $display("FAIL areset_pre got=%0d exp=1", sample_out); end
    idle(2);
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    checks++; if (read_addr_out !== 12'd0 || sample_out !== 16'd0) begin
      failures++; $display("FAIL areset_data got=%0d/%0d exp=0/0", read_addr_out, sample_out); end
    checks++; if ({sample_valid_out, busy_out, done_out, underrun_out} !== 4'b0000) begin
      failures++; $display("FAIL areset_flags got=%b exp=0000", {sample_valid_out, busy_out, done_out, underrun_out}); end
    @(negedge clk_in);
    rst_in = 1'b0;
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_negative();
    test_len_zero();
    test_underrun();
    test_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
